cp0_bypass_pipe: RTL
====================

Name: cp0_bypass_pipe

Overview:
Parametrised CP0 write pipeline with forwarding and a backing register file, the successor to the EX-stage CP0 forward mux.
- MTC0-style writes are issued at EX and carried through DEPTH registered stages, then committed to an internal CP0 register array.
- Read ports return the youngest in-flight value for the addressed register, otherwise the committed value.
- Adds valid-qualified matching, stall/flush handling, multiple read ports, and commit/occupancy visibility.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; array holds 2**ADDR_W entries
DEPTH, 2, in-flight stages between issue and commit (>=1)
NREAD, 1, number of read ports

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
stall  input  1  hold all in-flight stages; issue input ignored
flush  input  1  exception flush: kill uncommitted stages and issue input
wr_valid  input  1  write issue request
wr_addr  input  ADDR_W  write register address
wr_data  input  DATA_W  write data
rd_addr  input  NREAD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NREAD*DATA_W  read data per port
rd_hit  output  NREAD  1 = port data forwarded from an in-flight stage
commit_valid  output  1  stage DEPTH-1 commits on this edge
commit_addr  output  ADDR_W  committing address
commit_data  output  DATA_W  committing data
pending_count  output  $clog2(DEPTH+1)  number of valid in-flight stages

Behaviour:
Clock and reset
- One clock, clk.
- Reset is synchronous, active-low (rst_n sampled on the rising clk edge).
- On reset: all stage valid bits 0 and all array entries 0.
- Reset dominates stall, flush and wr_valid.
- Outputs after reset: rd_data 0, rd_hit 0, commit_valid 0, commit_addr 0, commit_data 0, pending_count 0.
- Reset asserted mid-operation discards in-flight writes without committing them.

Stages
- Stage k holds v[k], a[k], d[k]; stage 0 is youngest.

Edge update, in priority order
1. flush=1:
   - Stage DEPTH-1, if valid, commits to the array.
   - All v[k] clear; the issue input is dropped.
   - Flush overrides stall.
2. stall=1, flush=0:
   - All stages hold; no commit; the issue input is dropped.
   - The producer must hold the request.
3. Otherwise:
   - Stage k+1 takes stage k.
   - Stage 0 takes {wr_valid, wr_addr, wr_data}.
   - Stage DEPTH-1, if valid, writes array[a]=d.

Commit outputs
- commit_valid = v[DEPTH-1] & (~stall | flush).
- commit_addr and commit_data are a[DEPTH-1] and d[DEPTH-1].
- commit_addr and commit_data are don't-care when commit_valid=0 (driven 0 after reset).

Reads (combinational, per port)
- Scan stages 0 to DEPTH-1.
- The first stage with v=1 and a==rd_addr supplies rd_data, with rd_hit=1.
- With no match: rd_data = array[rd_addr], rd_hit=0.
- Matching requires v=1, so an invalid stage never matches. No spurious hit on address 0.
- The same address in several stages resolves to the youngest.
- A value still in stage DEPTH-1 is forwarded in its commit cycle and read from the array afterwards; no gap.
- The issue input of the current cycle is not forwarded.

Occupancy
- pending_count = popcount of v[0..DEPTH-1], combinational.

Test Plan:
1. Write forwarding (DEPTH=2, NREAD=1):
   - Stimulus: reset; issue wr addr 12 data 0xDEADBEEF for one cycle; rd_addr=12.
   - Cycle +1: rd_data=0xDEADBEEF, rd_hit=1, pending_count=1.
   - Cycle +2: commit_valid=1, commit_addr=12.
   - Cycle +3: rd_data=0xDEADBEEF, rd_hit=0, pending_count=0.
2. Youngest wins:
   - Stimulus: back-to-back writes addr 13: 0x1 then 0x2.
   - Next cycle: read 13 gives 0x2, rd_hit=1.
   - After both commit: array[13]=0x2.
3. Flush:
   - Stimulus: writes to addr 14 (0xAA) then addr 15 (0xBB); flush in the cycle the 14 write sits in stage 1.
   - Response: commit 14=0xAA occurs; 15 is never committed; read 15 gives 0, rd_hit=0; pending_count=0.
4. Stall:
   - Stimulus: 3-cycle stall with a write in stage 0.
   - Response: pending_count holds at 1; commit_valid=0; rd_hit stays 1; wr_valid during the stall is not captured.
   - After release: normal 2-cycle commit.
5. Reset and address-0 check:
   - Stimulus: rst_n low while both stages are valid; then rd_addr=0 with wr_valid=0.
   - Response: rd_data=0, rd_hit=0, pending_count=0; the pre-reset writes are absent from the array.
6. Parametrisation (DEPTH=4, NREAD=2):
   - Stimulus: write addr 9; read ports on 9 and 10.
   - Response: port0 hit for 4 cycles, then array value; port1 rd_hit=0 throughout.

Source files
------------

// File: rtl/cp0_bypass_pipe.sv
`timescale 1ns/1ps
// cp0_bypass_pipe: CP0 write pipeline with forwarding and a backing register file.
// Writes issued at EX travel through DEPTH registered stages and then commit
// to an internal CP0 register array. Each read port returns the youngest
// in-flight value for its address. If no stage holds that address, it returns
// the committed array value.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   stall           hold all stages, drop issue input
//   flush           kill uncommitted stages and issue input (oldest still commits)
//   wr_valid/addr/data  write issue request
//   rd_addr         NREAD packed read addresses
//   rd_data/rd_hit  per-port read data and in-flight forward indication
//   commit_valid/addr/data  oldest stage committing on this edge
//   pending_count   number of valid in-flight stages
module cp0_bypass_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned NREAD  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [NREAD*ADDR_W-1:0]      rd_addr,
  output logic [NREAD*DATA_W-1:0]      rd_data,
  output logic [NREAD-1:0]             rd_hit,
  output logic                         commit_valid,
  output logic [ADDR_W-1:0]            commit_addr,
  output logic [DATA_W-1:0]            commit_data,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAST  = DEPTH - 1;

  logic [DEPTH-1:0]  v_q, v_d;
  logic [ADDR_W-1:0] a_q [DEPTH];
  logic [ADDR_W-1:0] a_d [DEPTH];
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [DATA_W-1:0] mem_q [NREG];
  logic              advance;

  assign advance = ~stall & ~flush;

  // Oldest stage retires on a normal advance or on a flush (flush beats stall).
  assign commit_valid = v_q[LAST] & (~stall | flush);
  assign commit_addr  = a_q[LAST];
  assign commit_data  = d_q[LAST];

  // Stage next-state: flush kills all stages, stall holds them, otherwise shift in the issue.
  always_comb begin
    v_d = v_q;
    a_d = a_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else if (advance) begin
      v_d[0] = wr_valid;
      a_d[0] = wr_addr;
      d_d[0] = wr_data;
      for (int k = 1; k < int'(DEPTH); k++) begin
        v_d[k] = v_q[k-1];
        a_d[k] = a_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  // Stage registers and register array. Reset drops in-flight writes uncommitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        a_q[k] <= '0;
        d_q[k] <= '0;
      end
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      d_q <= d_d;
      if (commit_valid) begin
        mem_q[commit_addr] <= commit_data;
      end
    end
  end

  // Per-port forwarding. Scan oldest to youngest so the youngest match is applied last.
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              hit;

    assign ra = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = mem_q[ra];
      hit  = 1'b0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (v_q[k] && (a_q[k] == ra)) begin
          rdat = d_q[k];
          hit  = 1'b1;
        end
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = rdat;
    assign rd_hit[p]                   = hit;
  end

  // Occupancy: popcount of the stage valid bits.
  always_comb begin
    pending_count = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      pending_count = pending_count + CNT_W'(v_q[k]);
    end
  end

endmodule
